fft_input_buffer: RTL

FFT_INPUT_BUFFER -- requirements
Module: fft_input_buffer

---
 rtl/fft_pkg.sv | 10 +
 rtl/fft_frame_bank.sv | 33 +++
 rtl/fft_input_buffer.sv | 90 +++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared types and default sizes for the FFT input buffering path.
package fft_pkg;

  localparam int unsigned FFT_N    = 32;
  localparam int unsigned SAMPLE_W = 16;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef sample_t [FFT_N-1:0] frame_t;

endpackage

// File: rtl/fft_frame_bank.sv
// One frame of sample storage: single indexed write port, whole frame visible in parallel.
module fft_frame_bank #(
  parameter int unsigned SAMPLE_W = fft_pkg::SAMPLE_W,
  parameter int unsigned FFT_N    = fft_pkg::FFT_N
) (
  input  logic                               clk,
  input  logic                               n_rst,
  input  logic                               wr_en,
  input  logic [$clog2(FFT_N)-1:0]           wr_idx,
  input  logic [SAMPLE_W-1:0]                wr_data,
  output logic [FFT_N-1:0][SAMPLE_W-1:0]     frame
);

  logic [FFT_N-1:0][SAMPLE_W-1:0] frame_d, frame_q;

  always_comb begin
    frame_d = frame_q;
    if (wr_en) begin
      frame_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      frame_q <= '0;
    end else begin
      frame_q <= frame_d;
    end
  end

  assign frame = frame_q;

endmodule

// File: rtl/fft_input_buffer.sv
// Ping-pong serial-to-parallel frame buffer: fills one bank while the other is presented
// to the consumer until acknowledged.
module fft_input_buffer #(
  parameter int unsigned SAMPLE_W = fft_pkg::SAMPLE_W,
  parameter int unsigned FFT_N    = fft_pkg::FFT_N
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic [SAMPLE_W-1:0]            in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           sync_clear,
  output logic [FFT_N-1:0][SAMPLE_W-1:0] frame_data,
  output logic                           frame_valid,
  input  logic                           frame_ack,
  output logic [$clog2(FFT_N)-1:0]       fill_level
);

  localparam int unsigned CntW = $clog2(FFT_N);

  logic [1:0]      full_d, full_q;
  logic            wr_sel_d, wr_sel_q;
  logic            rd_sel_d, rd_sel_q;
  logic [CntW-1:0] wr_cnt_d, wr_cnt_q;

  logic accept, last, ack;
  logic [FFT_N-1:0][SAMPLE_W-1:0] bank_frame [2];

  assign in_ready    = ~full_q[wr_sel_q];
  assign frame_valid = full_q[rd_sel_q];
  assign frame_data  = bank_frame[rd_sel_q];
  assign fill_level  = wr_cnt_q;

  assign accept = in_valid & in_ready & ~sync_clear;
  assign last   = (wr_cnt_q == CntW'(FFT_N - 1));
  assign ack    = frame_ack & frame_valid;

  // Write and read banks can never coincide while both ack and completion fire,
  // since completion needs the write bank empty and ack needs the read bank full.
  always_comb begin
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    wr_cnt_d = wr_cnt_q;
    if (ack) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end
    if (sync_clear) begin
      wr_cnt_d = '0;
    end else if (accept) begin
      if (last) begin
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = ~wr_sel_q;
        wr_cnt_d         = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      full_q   <= 2'b00;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_cnt_q <= '0;
    end else begin
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_frame_bank #(
      .SAMPLE_W (SAMPLE_W),
      .FFT_N    (FFT_N)
    ) u_bank (
      .clk     (clk),
      .n_rst   (n_rst),
      .wr_en   (accept && (wr_sel_q == 1'(b))),
      .wr_idx  (wr_cnt_q),
      .wr_data (in_data),
      .frame   (bank_frame[b])
    );
  end

endmodule
